// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator.
// A pixel-rate enable is derived from the system clock, and free-running
// horizontal/vertical counters advance on it. Every output is registered and
// decoded from the post-update count, so counts, bright and syncs agree on the
// same clock. An optional shift register delays only hSync/vSync/bright so they
// can line up with a downstream pixel pipeline.
module vga_timing_gen #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic H_POL      = 1'b0,
    parameter logic V_POL      = 1'b0,
    parameter int   PIX_DIV    = 2,
    parameter int   SYNC_DELAY = 0,
    parameter int   CNT_W      = 10
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             enable,
    output logic             pixTick,
    output logic             hSync,
    output logic             vSync,
    output logic             bright,
    output logic [CNT_W-1:0] hCount,
    output logic [CNT_W-1:0] vCount,
    output logic             lineStart,
    output logic             frameStart
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int NSTAGE  = SYNC_DELAY + 1;

    // Region boundaries are kept as inclusive last values so that a mode with
    // a zero-length back porch never needs a constant of H_TOTAL itself.
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(PIX_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS_END = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_VIS_END = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] HS_FIRST  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Stage layout is {hSync, vSync, bright}; idle means syncs inactive, dark.
    localparam logic [2:0] IDLE_LVL = {~H_POL, ~V_POL, 1'b0};

    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_hCount;
    logic [CNT_W-1:0] r_vCount;
    logic             r_pixTick;
    logic             r_lineStart;
    logic             r_frameStart;
    logic [2:0]       r_stage [NSTAGE];

    logic             w_tick;
    logic             w_hWrap;
    logic [CNT_W-1:0] w_hNext;
    logic [CNT_W-1:0] w_vNext;
    logic             w_hSyncAct;
    logic             w_vSyncAct;
    logic             w_visible;
    logic [2:0]       w_decode;

    // Next-count arithmetic and region decode of the count about to be loaded.
    always_comb begin
        w_tick     = enable && (r_div == DIV_LAST);
        w_hWrap    = (r_hCount == H_LAST);
        w_hNext    = w_hWrap ? '0 : r_hCount + 1'b1;
        w_vNext    = r_vCount;
        if (w_hWrap) begin
            w_vNext = (r_vCount == V_LAST) ? '0 : r_vCount + 1'b1;
        end
        w_visible  = (w_hNext <= H_VIS_END) && (w_vNext <= V_VIS_END);
        w_hSyncAct = (w_hNext >= HS_FIRST) && (w_hNext <= HS_LAST);
        w_vSyncAct = (w_vNext >= VS_FIRST) && (w_vNext <= VS_LAST);
        w_decode   = {w_hSyncAct ? H_POL : ~H_POL,
                      w_vSyncAct ? V_POL : ~V_POL,
                      w_visible};
    end

    // Pixel divider: counts enabled clocks and restarts from zero whenever
    // enable drops, so the first tick after re-enable is PIX_DIV clocks away.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_div <= '0;
        end else if (!enable || (r_div == DIV_LAST)) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Raster counters start at the last position so the first tick lands on (0,0).
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_hCount <= H_LAST;
            r_vCount <= V_LAST;
        end else if (w_tick) begin
            r_hCount <= w_hNext;
            r_vCount <= w_vNext;
        end
    end

    // One-clock strobes aligned with the counts they describe.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_pixTick    <= 1'b0;
            r_lineStart  <= 1'b0;
            r_frameStart <= 1'b0;
        end else begin
            r_pixTick    <= w_tick;
            r_lineStart  <= w_tick && (w_hNext == '0);
            r_frameStart <= w_tick && (w_hNext == '0) && (w_vNext == '0);
        end
    end

    // Sync/bright stages: stage 0 tracks the counts, later stages lag by one tick each.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NSTAGE; i++) begin
                r_stage[i] <= IDLE_LVL;
            end
        end else if (w_tick) begin
            r_stage[0] <= w_decode;
            for (int i = 1; i < NSTAGE; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign pixTick    = r_pixTick;
    assign lineStart  = r_lineStart;
    assign frameStart = r_frameStart;
    assign hCount     = r_hCount;
    assign vCount     = r_vCount;
    assign hSync      = r_stage[SYNC_DELAY][2];
    assign vSync      = r_stage[SYNC_DELAY][1];
    assign bright     = r_stage[SYNC_DELAY][0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: four configurations of vga_timing_gen share clock, clear
// and enable. A tick-count model predicts every output: after k pixel ticks the
// raster position is simply (k-1) mod frame size, and delayed outputs are the
// decode of position k-SYNC_DELAY.
module tb_vga_timing_gen;

    // Instance 0 default mode, 1 tall vertical/short lines, 2 inverted polarity,
    // 3 divided clock with a two-tick sync/bright delay.
    localparam int HA [4] = '{640, 8, 8, 8};
    localparam int HF [4] = '{16, 2, 2, 2};
    localparam int HS [4] = '{96, 2, 2, 2};
    localparam int HB [4] = '{48, 2, 2, 2};
    localparam int VA [4] = '{480, 480, 4, 4};
    localparam int VF [4] = '{10, 10, 1, 1};
    localparam int VS [4] = '{2, 2, 1, 1};
    localparam int VB [4] = '{33, 33, 1, 1};
    localparam int HP [4] = '{0, 0, 1, 0};
    localparam int VP [4] = '{0, 0, 1, 0};
    localparam int DV [4] = '{2, 1, 1, 3};
    localparam int DL [4] = '{0, 0, 0, 2};

    logic clock = 1'b0;
    logic clear;
    logic enable;

    logic d_pixTick, d_hSync, d_vSync, d_bright, d_lineStart, d_frameStart;
    logic v_pixTick, v_hSync, v_vSync, v_bright, v_lineStart, v_frameStart;
    logic p_pixTick, p_hSync, p_vSync, p_bright, p_lineStart, p_frameStart;
    logic s_pixTick, s_hSync, s_vSync, s_bright, s_lineStart, s_frameStart;
    logic [9:0] d_hCount, d_vCount, v_hCount, v_vCount;
    logic [9:0] p_hCount, p_vCount, s_hCount, s_vCount;

    logic [25:0] obs [4];

    int mK [4];
    int mRun [4];
    logic mTick [4];

    int checks = 0;
    int passed = 0;

    always #5 clock = ~clock;

    vga_timing_gen u_def (
        .clock(clock), .clear(clear), .enable(enable),
        .pixTick(d_pixTick), .hSync(d_hSync), .vSync(d_vSync), .bright(d_bright),
        .hCount(d_hCount), .vCount(d_vCount),
        .lineStart(d_lineStart), .frameStart(d_frameStart)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .PIX_DIV(1)
    ) u_vert (
        .clock(clock), .clear(clear), .enable(enable),
        .pixTick(v_pixTick), .hSync(v_hSync), .vSync(v_vSync), .bright(v_bright),
        .hCount(v_hCount), .vCount(v_vCount),
        .lineStart(v_lineStart), .frameStart(v_frameStart)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .PIX_DIV(1)
    ) u_pol (
        .clock(clock), .clear(clear), .enable(enable),
        .pixTick(p_pixTick), .hSync(p_hSync), .vSync(p_vSync), .bright(p_bright),
        .hCount(p_hCount), .vCount(p_vCount),
        .lineStart(p_lineStart), .frameStart(p_frameStart)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .PIX_DIV(3), .SYNC_DELAY(2)
    ) u_dly (
        .clock(clock), .clear(clear), .enable(enable),
        .pixTick(s_pixTick), .hSync(s_hSync), .vSync(s_vSync), .bright(s_bright),
        .hCount(s_hCount), .vCount(s_vCount),
        .lineStart(s_lineStart), .frameStart(s_frameStart)
    );

    assign obs[0] = {d_pixTick, d_hSync, d_vSync, d_bright, d_lineStart, d_frameStart, d_hCount, d_vCount};
    assign obs[1] = {v_pixTick, v_hSync, v_vSync, v_bright, v_lineStart, v_frameStart, v_hCount, v_vCount};
    assign obs[2] = {p_pixTick, p_hSync, p_vSync, p_bright, p_lineStart, p_frameStart, p_hCount, p_vCount};
    assign obs[3] = {s_pixTick, s_hSync, s_vSync, s_bright, s_lineStart, s_frameStart, s_hCount, s_vCount};

    // Expected packed outputs for one instance from its tick count alone.
    function automatic logic [25:0] expPack(input int id);
        int hT, vT, p, h, v, kd, hd, vd;
        logic hPol, vPol, b, hs, vs, ls, fs, t;
        hT   = HA[id] + HF[id] + HS[id] + HB[id];
        vT   = VA[id] + VF[id] + VS[id] + VB[id];
        hPol = (HP[id] != 0);
        vPol = (VP[id] != 0);
        t    = mTick[id];
        if (mK[id] == 0) begin
            h = hT - 1;
            v = vT - 1;
        end else begin
            p = (mK[id] - 1) % (hT * vT);
            h = p % hT;
            v = p / hT;
        end
        ls = t && (h == 0);
        fs = ls && (v == 0);
        kd = mK[id] - DL[id];
        b  = 1'b0;
        hs = ~hPol;
        vs = ~vPol;
        if (kd >= 1) begin
            p  = (kd - 1) % (hT * vT);
            hd = p % hT;
            vd = p / hT;
            b  = (hd < HA[id]) && (vd < VA[id]);
            hs = ((hd >= HA[id] + HF[id]) && (hd < HA[id] + HF[id] + HS[id])) ? hPol : ~hPol;
            vs = ((vd >= VA[id] + VF[id]) && (vd < VA[id] + VF[id] + VS[id])) ? vPol : ~vPol;
        end
        return {t, hs, vs, b, ls, fs, h[9:0], v[9:0]};
    endfunction

    task automatic modelReset();
        for (int id = 0; id < 4; id++) begin
            mK[id]    = 0;
            mRun[id]  = 0;
            mTick[id] = 1'b0;
        end
    endtask

    // Advance one clock; a tick happens on every PIX_DIV-th consecutive enabled edge.
    task automatic step();
        @(posedge clock);
        for (int id = 0; id < 4; id++) begin
            if (!clear) begin
                mK[id]    = 0;
                mRun[id]  = 0;
                mTick[id] = 1'b0;
            end else if (enable) begin
                mRun[id]  = mRun[id] + 1;
                mTick[id] = ((mRun[id] % DV[id]) == 0);
                if (mTick[id]) mK[id] = mK[id] + 1;
            end else begin
                mRun[id]  = 0;
                mTick[id] = 1'b0;
            end
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        clear  = 1'b0;
        enable = 1'b1;
        modelReset();
        repeat (3) step();
        for (int id = 0; id < 4; id++) begin
            checks++; if (obs[id] !== expPack(id)) $display("[TB] FAIL reset_state id%0d: got %h want %h", id, obs[id], expPack(id)); else passed++;
        end
        checks++; if (d_hCount !== 10'd799) $display("[TB] FAIL reset_hCount: got %0d want 799", d_hCount); else passed++;
        checks++; if (d_vCount !== 10'd524) $display("[TB] FAIL reset_vCount: got %0d want 524", d_vCount); else passed++;
        checks++; if ({d_bright, d_hSync, d_vSync, d_pixTick} !== 4'b0110) $display("[TB] FAIL reset_outputs: got %b want 0110", {d_bright, d_hSync, d_vSync, d_pixTick}); else passed++;
        checks++; if ({p_hSync, p_vSync} !== 2'b00) $display("[TB] FAIL reset_pol_syncs: got %b want 00", {p_hSync, p_vSync}); else passed++;
        clear = 1'b1;
        step();
        checks++; if ({d_pixTick, d_hCount} !== {1'b0, 10'd799}) $display("[TB] FAIL no_tick_clock1: got tick %b h %0d want tick 0 h 799", d_pixTick, d_hCount); else passed++;
        checks++; if ({p_pixTick, p_frameStart, p_hCount} !== {2'b11, 10'd0}) $display("[TB] FAIL pixdiv1_clock1: got tick %b fs %b h %0d want 1 1 0", p_pixTick, p_frameStart, p_hCount); else passed++;
        step();
        checks++; if ({d_pixTick, d_lineStart, d_frameStart, d_bright} !== 4'b1111) $display("[TB] FAIL first_tick_strobes: got %b want 1111", {d_pixTick, d_lineStart, d_frameStart, d_bright}); else passed++;
        checks++; if ({d_hCount, d_vCount} !== 20'd0) $display("[TB] FAIL first_tick_counts: got %0d,%0d want 0,0", d_hCount, d_vCount); else passed++;
        step();
        checks++; if ({d_pixTick, d_lineStart, d_hCount} !== {2'b00, 10'd0}) $display("[TB] FAIL tick_single_pulse: got tick %b ls %b h %0d want 0 0 0", d_pixTick, d_lineStart, d_hCount); else passed++;
    endtask

    task automatic test_horizontal();
        int fallH = -1, hsMin = 99999, hsMax = -1, hsLow = 0;
        int lsSeen = 0, lsFirst = 0, lsPeriod = 0;
        logic prevB = d_bright;
        for (int c = 1; c <= 3300; c++) begin
            step();
            for (int id = 0; id < 4; id++) begin
                checks++; if (obs[id] !== expPack(id)) $display("[TB] FAIL horiz_model id%0d: got %h want %h", id, obs[id], expPack(id)); else passed++;
            end
            if (prevB && !d_bright && fallH < 0) fallH = int'(d_hCount);
            prevB = d_bright;
            if (d_lineStart) begin
                lsSeen++;
                if (lsSeen == 1) lsFirst = c;
                else if (lsSeen == 2) lsPeriod = c - lsFirst;
            end
            if (!d_hSync) begin
                if (int'(d_hCount) < hsMin) hsMin = int'(d_hCount);
                if (int'(d_hCount) > hsMax) hsMax = int'(d_hCount);
                if (lsSeen == 1) hsLow++;
            end
        end
        checks++; if (fallH != 640) $display("[TB] FAIL bright_fall_h: got %0d want 640", fallH); else passed++;
        checks++; if (hsMin != 656) $display("[TB] FAIL hsync_first: got %0d want 656", hsMin); else passed++;
        checks++; if (hsMax != 751) $display("[TB] FAIL hsync_last: got %0d want 751", hsMax); else passed++;
        checks++; if (hsLow != 192) $display("[TB] FAIL hsync_clocks: got %0d want 192", hsLow); else passed++;
        checks++; if (lsPeriod != 1600) $display("[TB] FAIL line_period: got %0d want 1600", lsPeriod); else passed++;
    endtask

    task automatic test_vertical();
        int vsMin = 99999, vsMax = -1, vsLow = 0, brightBad = 0;
        int fsSeen = 0, fsFirst = 0, fsPeriod = 0;
        clear = 1'b0;
        step();
        clear = 1'b1;
        for (int c = 1; c <= 15000; c++) begin
            step();
            for (int id = 0; id < 4; id++) begin
                checks++; if (obs[id] !== expPack(id)) $display("[TB] FAIL vert_model id%0d: got %h want %h", id, obs[id], expPack(id)); else passed++;
            end
            if (v_frameStart) begin
                fsSeen++;
                if (fsSeen == 1) fsFirst = c;
                else if (fsSeen == 2) fsPeriod = c - fsFirst;
            end
            if (!v_vSync) begin
                if (int'(v_vCount) < vsMin) vsMin = int'(v_vCount);
                if (int'(v_vCount) > vsMax) vsMax = int'(v_vCount);
                if (fsSeen == 1) vsLow++;
            end
            if (v_bright && (v_vCount >= 10'd480)) brightBad++;
        end
        checks++; if (vsMin != 490) $display("[TB] FAIL vsync_first: got %0d want 490", vsMin); else passed++;
        checks++; if (vsMax != 491) $display("[TB] FAIL vsync_last: got %0d want 491", vsMax); else passed++;
        checks++; if (vsLow != 28) $display("[TB] FAIL vsync_clocks: got %0d want 28", vsLow); else passed++;
        checks++; if (brightBad != 0) $display("[TB] FAIL bright_in_vblank: got %0d want 0", brightBad); else passed++;
        checks++; if (fsPeriod != 7350) $display("[TB] FAIL frame_period: got %0d want 7350", fsPeriod); else passed++;
    endtask

    task automatic test_polarity();
        int hsMin = 99999, hsMax = -1, vsMin = 99999, vsMax = -1, hMax = -1;
        int lsSeen = 0, lsFirst = 0, lsPeriod = 0, fsSeen = 0, fsFirst = 0, fsPeriod = 0;
        for (int c = 1; c <= 200; c++) begin
            step();
            for (int id = 0; id < 4; id++) begin
                checks++; if (obs[id] !== expPack(id)) $display("[TB] FAIL pol_model id%0d: got %h want %h", id, obs[id], expPack(id)); else passed++;
            end
            if (p_hSync) begin
                if (int'(p_hCount) < hsMin) hsMin = int'(p_hCount);
                if (int'(p_hCount) > hsMax) hsMax = int'(p_hCount);
            end
            if (p_vSync) begin
                if (int'(p_vCount) < vsMin) vsMin = int'(p_vCount);
                if (int'(p_vCount) > vsMax) vsMax = int'(p_vCount);
            end
            if (int'(p_hCount) > hMax) hMax = int'(p_hCount);
            if (p_lineStart) begin
                lsSeen++;
                if (lsSeen == 1) lsFirst = c;
                else if (lsSeen == 2) lsPeriod = c - lsFirst;
            end
            if (p_frameStart) begin
                fsSeen++;
                if (fsSeen == 1) fsFirst = c;
                else if (fsSeen == 2) fsPeriod = c - fsFirst;
            end
        end
        checks++; if ({hsMin, hsMax} != {32'sd10, 32'sd11}) $display("[TB] FAIL pol_hsync_range: got %0d..%0d want 10..11", hsMin, hsMax); else passed++;
        checks++; if ({vsMin, vsMax} != {32'sd5, 32'sd5}) $display("[TB] FAIL pol_vsync_range: got %0d..%0d want 5..5", vsMin, vsMax); else passed++;
        checks++; if (hMax != 13) $display("[TB] FAIL pol_h_max: got %0d want 13", hMax); else passed++;
        checks++; if (lsPeriod != 14) $display("[TB] FAIL pol_line_period: got %0d want 14", lsPeriod); else passed++;
        checks++; if (fsPeriod != 98) $display("[TB] FAIL pol_frame_period: got %0d want 98", fsPeriod); else passed++;
    endtask

    task automatic test_sync_delay();
        int hsMin = 99999, hsMax = -1, fallH = -1;
        logic prevB;
        clear = 1'b0;
        step();
        clear = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            step();
            for (int id = 0; id < 4; id++) begin
                checks++; if (obs[id] !== expPack(id)) $display("[TB] FAIL dly_fill_model id%0d: got %h want %h", id, obs[id], expPack(id)); else passed++;
            end
            if (c == 3) begin
                checks++; if ({s_pixTick, s_bright, s_hSync, s_hCount} !== {3'b101, 10'd0}) $display("[TB] FAIL dly_tick1: got tick %b b %b hs %b h %0d want 1 0 1 0", s_pixTick, s_bright, s_hSync, s_hCount); else passed++;
            end
            if (c == 4) begin
                checks++; if (s_pixTick !== 1'b0) $display("[TB] FAIL dly_tick_gap: got %b want 0", s_pixTick); else passed++;
            end
            if (c == 6) begin
                checks++; if ({s_bright, s_hCount} !== {1'b0, 10'd1}) $display("[TB] FAIL dly_tick2: got b %b h %0d want 0 1", s_bright, s_hCount); else passed++;
            end
            if (c == 9) begin
                checks++; if ({s_bright, s_hCount} !== {1'b1, 10'd2}) $display("[TB] FAIL dly_tick3: got b %b h %0d want 1 2", s_bright, s_hCount); else passed++;
            end
        end
        prevB = s_bright;
        for (int c = 1; c <= 300; c++) begin
            step();
            for (int id = 0; id < 4; id++) begin
                checks++; if (obs[id] !== expPack(id)) $display("[TB] FAIL dly_model id%0d: got %h want %h", id, obs[id], expPack(id)); else passed++;
            end
            if (prevB && !s_bright && fallH < 0) fallH = int'(s_hCount);
            prevB = s_bright;
            if (!s_hSync) begin
                if (int'(s_hCount) < hsMin) hsMin = int'(s_hCount);
                if (int'(s_hCount) > hsMax) hsMax = int'(s_hCount);
            end
        end
        checks++; if ({hsMin, hsMax} != {32'sd12, 32'sd13}) $display("[TB] FAIL dly_hsync_range: got %0d..%0d want 12..13", hsMin, hsMax); else passed++;
        checks++; if (fallH != 10) $display("[TB] FAIL dly_bright_fall: got %0d want 10", fallH); else passed++;
    endtask

    task automatic test_enable_gating();
        int found = 0, frozenBad = 0;
        for (int c = 1; c <= 3300; c++) begin
            step();
            if (d_pixTick && (d_hCount == 10'd300)) begin
                found = 1;
                break;
            end
        end
        checks++; if (found != 1) $display("[TB] FAIL enable_wait_h300: got timeout want hCount 300"); else passed++;
        enable = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            step();
            for (int id = 0; id < 4; id++) begin
                checks++; if (obs[id] !== expPack(id)) $display("[TB] FAIL gate_model id%0d: got %h want %h", id, obs[id], expPack(id)); else passed++;
            end
            if ((d_hCount !== 10'd300) || d_pixTick || p_pixTick || d_lineStart) frozenBad++;
        end
        checks++; if (frozenBad != 0) $display("[TB] FAIL gate_frozen: got %0d bad clocks want 0", frozenBad); else passed++;
        enable = 1'b1;
        step();
        checks++; if ({d_pixTick, d_hCount} !== {1'b0, 10'd300}) $display("[TB] FAIL resume_clock1: got tick %b h %0d want 0 300", d_pixTick, d_hCount); else passed++;
        step();
        checks++; if ({d_pixTick, d_hCount} !== {1'b1, 10'd301}) $display("[TB] FAIL resume_clock2: got tick %b h %0d want 1 301", d_pixTick, d_hCount); else passed++;
    endtask

    task automatic test_mid_reset();
        int found = 0;
        for (int c = 1; c <= 8000; c++) begin
            step();
            if (v_vCount == 10'd200) begin
                found = 1;
                break;
            end
        end
        checks++; if (found != 1) $display("[TB] FAIL midreset_wait_v200: got timeout want vCount 200"); else passed++;
        clear = 1'b0;
        modelReset();
        #1;
        for (int id = 0; id < 4; id++) begin
            checks++; if (obs[id] !== expPack(id)) $display("[TB] FAIL midreset_model id%0d: got %h want %h", id, obs[id], expPack(id)); else passed++;
        end
        checks++; if ({d_hCount, d_vCount} !== {10'd799, 10'd524}) $display("[TB] FAIL midreset_def_counts: got %0d,%0d want 799,524", d_hCount, d_vCount); else passed++;
        checks++; if ({v_hCount, v_vCount} !== {10'd13, 10'd524}) $display("[TB] FAIL midreset_vert_counts: got %0d,%0d want 13,524", v_hCount, v_vCount); else passed++;
        checks++; if ({v_bright, v_vSync, v_hSync, v_pixTick} !== 4'b0110) $display("[TB] FAIL midreset_outputs: got %b want 0110", {v_bright, v_vSync, v_hSync, v_pixTick}); else passed++;
        step();
        clear = 1'b1;
        step();
        checks++; if ({v_pixTick, v_frameStart, v_hCount, v_vCount} !== {2'b11, 20'd0}) $display("[TB] FAIL midreset_restart: got %h want %h", {v_pixTick, v_frameStart, v_hCount, v_vCount}, {2'b11, 20'd0}); else passed++;
    endtask

    task automatic test_random();
        for (int c = 1; c <= 3000; c++) begin
            enable = ($urandom_range(0, 9) != 0);
            clear  = ($urandom_range(0, 399) != 0);
            step();
            for (int id = 0; id < 4; id++) begin
                checks++; if (obs[id] !== expPack(id)) $display("[TB] FAIL random_model id%0d cycle %0d: got %h want %h", id, c, obs[id], expPack(id)); else passed++;
            end
        end
        clear  = 1'b1;
        enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_vertical();
        test_polarity();
        test_sync_delay();
        test_enable_gating();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised raster timing generator; successor to the fixed 640x480 VGA controller.
- Derives a pixel-rate enable from the system clock and runs free horizontal/vertical counters.
- Produces sync, bright, line/frame strobes and per-pixel counts consumed by bit-generation logic.
- Supports any mode, sync polarity, pixel divider, and an optional sync/bright delay to match downstream pixel-pipeline latency.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync pulse (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync pulse (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, active level of hSync (0 = active-low)
V_POL, 0, active level of vSync
PIX_DIV, 2, system clocks per pixel (>=1; 2 gives 25 MHz from 50 MHz)
SYNC_DELAY, 0, pixel ticks of delay applied to hSync/vSync/bright only (0..7)
CNT_W, 10, width of hCount/vCount (must hold H_TOTAL-1 and V_TOTAL-1)

Ports:
clock  in  1  system clock
clear  in  1  asynchronous active-low reset
enable  in  1  run when high; freeze raster when low
pixTick  out  1  one-clock pulse per pixel period
hSync  out  1  horizontal sync, polarity H_POL
vSync  out  1  vertical sync, polarity V_POL
bright  out  1  high when current pixel is in the active area
hCount  out  CNT_W  horizontal position, 0..H_TOTAL-1
vCount  out  CNT_W  vertical position, 0..V_TOTAL-1
lineStart  out  1  one-clock pulse when hCount becomes 0
frameStart  out  1  one-clock pulse when hCount and vCount both become 0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Line order: active, front porch, sync, back porch; frame order the same in lines.
- Reset (clear low, async):
  - Divider = 0; hCount = H_TOTAL-1; vCount = V_TOTAL-1.
  - bright = 0; hSync/vSync = inactive level (~H_POL, ~V_POL).
  - pixTick, lineStart, frameStart = 0; delay-line stages cleared to the inactive levels.
- Divider:
  - Counts 0..PIX_DIV-1 while enable is high.
  - pixTick is asserted for the clock in which the divider equals PIX_DIV-1, then the divider wraps.
  - PIX_DIV = 1 gives pixTick constantly high while enabled.
- Counters advance only on pixTick:
  - hCount increments and wraps H_TOTAL-1 -> 0.
  - On that wrap, vCount increments and wraps V_TOTAL-1 -> 0.
  - First pixTick after reset therefore yields (0,0) with frameStart.
- All outputs are registered and computed from the post-update count in the same edge, so hCount, vCount, bright and syncs are mutually consistent (zero-latency relation to the counts).
- Region decode:
  - bright = (h < H_ACTIVE) && (v < V_ACTIVE).
  - hSync active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vSync active for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, over whole lines.
- SYNC_DELAY = N > 0: hSync, vSync and bright pass through an N-stage shift register advanced on pixTick. Counts and strobes are not delayed.
- lineStart / frameStart:
  - Pulse for exactly the clock edge on which the counts take value h = 0 (and v = 0 for frameStart).
  - A frameStart clock also has lineStart high.
- enable low:
  - Divider held at 0; counters, syncs, bright and delay line hold their values.
  - pixTick, lineStart and frameStart are 0.
  - On re-enable, the first pixTick comes PIX_DIV clocks later.
- clear asserted mid-frame returns all state to the reset values immediately, with no completion of the current line.
- Counters never exceed H_TOTAL-1 / V_TOTAL-1. Out-of-range CNT_W is a configuration error and is not handled.

Test Plan:
- Reset/first tick (defaults), clear low 3 clocks then high, enable = 1 -> hCount = 799, vCount = 524, bright = 0 before tick; first pixTick at clock 2 gives hCount = 0, vCount = 0, bright = 1, lineStart = frameStart = 1.
- Horizontal timing (defaults) -> bright falls at hCount = 640; hSync low exactly for hCount 656..751 (96 ticks = 192 clocks); lineStart period 1600 clocks.
- Vertical timing (defaults) -> vSync low for vCount 490..491 only (2 full lines); bright = 0 for all vCount >= 480; frameStart period 840000 clocks.
- Polarity/mode: H_POL = 1, V_POL = 1, PIX_DIV = 1, small mode 8/2/2/2 x 4/1/1/1 -> hSync high on hCount 10..11, H_TOTAL = 14, frame = 98 clocks.
- SYNC_DELAY = 2 -> bright and hSync lag the ideal decode by exactly 2 pixTicks, hCount undelayed; after reset the delay outputs read inactive until filled.
- Enable gating and mid-frame reset:
  - Drop enable at hCount = 300 for 50 clocks -> counts frozen, pixTick = 0; resume with hCount = 301 after PIX_DIV clocks.
  - Pulse clear at vCount = 200 -> immediate return to 799/524, outputs inactive.
